exp_range_sequencer: RTL and testbench
======================================

# exp_range_sequencer

Sequencer that wraps the hyperbolic-CORDIC exponential core so it can evaluate exp(x) over a wide input range. It accepts one Q16.16 operand per transaction over a valid/ready handshake. It range-reduces the operand to x = k·ln2 + r with r in [0, ln2), drives r into the external exponential core, holds the core inputs for the core latency, then scales the core result by 2^k. It sits between the activation-function front end and the shared exponential core instance.

## Interface
- XY_SZ, 16: core X/Y width; the core exp output is XY_SZ+2 bits.
- CORE_LAT, 16: cycles the core inputs are held before its output is sampled.
- CORE_FRAC, 14: fractional bits of the core exp output.
- X_INIT, 16'd19898: gain-compensated Xin (1/K_h in core format).
- LN2_Q16, 32'd45426: ln2 in Q16.16.
- MAX_K, 14: largest positive exponent before saturation.
- MIN_K, 16: largest negative exponent magnitude before flush-to-zero.
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand valid.
- in_ready, output, 1: sequencer idle, can accept an operand.
- in_x, input, 32: signed Q16.16 operand.
- core_angle, output, 32: signed angle r to the core (Q16.16).
- core_xin, output, XY_SZ: core Xin, driven to X_INIT while busy.
- core_yin, output, XY_SZ: core Yin, always 0.
- core_exp, input, XY_SZ+2: signed core result, Q(CORE_FRAC).
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_y, output, 32: exp(in_x), signed Q16.16, always ≥ 0.
- sat, output, 1: result was saturated or flushed to zero. Present only with EXP_SAT_FLAG_EN.

## Operation
- FSM states: IDLE, REDUCE, WAIT, SCALE, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: latch r=in_x, clear k, go to REDUCE.
- REDUCE: one step per cycle, evaluated in this order:
  - r<0: r+=LN2_Q16, k-=1.
  - r≥LN2_Q16: r-=LN2_Q16, k+=1.
  - Otherwise: register core_angle=r, start the wait counter, go to WAIT.
- REDUCE early exits (core not used):
  - k reaches MAX_K+1: out_y=32'h7FFF_FFFF, sat=1, go to DONE.
  - k reaches −(MIN_K+1): out_y=0, sat=1, go to DONE.
- WAIT
  - core_angle, core_xin and core_yin are held stable.
  - Counter runs for CORE_LAT cycles, then go to SCALE.
- SCALE
  - Sample core_exp; treat negative values as 0.
  - v = core_exp aligned to Q16.16: shift left by (16−CORE_FRAC), or right if that is negative.
  - k≥0: out_y = v<<k. Computed at ≥48 bits; any result above 32'h7FFF_FFFF saturates to it, sat=1.
  - k<0: out_y = v>>>(−k), truncating.
  - Go to DONE.
- DONE
  - out_valid=1; out_y and sat are held.
  - On out_ready: go to IDLE.
- core_angle is 0 in IDLE. core_xin is 0 in IDLE and X_INIT in every other state.

## Timing
- Reset values: in_ready=1, out_valid=0, out_y=0, sat=0, core_angle=0, core_xin=0, core_yin=0, FSM=IDLE, k=0.
- rst is sampled every edge. Asserting it in any state aborts the transaction, discards the operand, and returns to the reset values on the next edge.
- in_ready is deasserted the cycle after acceptance. No second operand is accepted until DONE completes.
- Latency from the accepting edge to out_valid rising:
  - Normal path: |k|+1 (REDUCE) + CORE_LAT (WAIT) + 1 (SCALE) cycles.
  - Saturate or flush-to-zero path: REDUCE cycles only.
- Backpressure: while out_ready=0, DONE holds indefinitely with outputs stable.
- Return to IDLE: out_valid and out_ready both high → in_ready=1 on the next cycle. There is no same-cycle turnaround.
- Boundary values:
  - in_x = LN2_Q16 exactly reduces to k=1, r=0.
  - in_x = −1 reduces to k=−1, r=LN2_Q16−1.

## Configuration
- EXP_SAT_FLAG_EN defined:
  - The sat port exists.
  - It is set in every saturate or flush case and cleared on each accept.
- EXP_SAT_FLAG_EN undefined:
  - The sat port and its register are removed.
  - Saturation and flush values on out_y are unchanged.

## Test plan
The bench uses a behavioural core model that returns round(e^angle·2^CORE_FRAC) after CORE_LAT cycles. Parameters are default unless noted.
- in_x=0, out_ready=1 → out_y=32'h0001_0000 (±2 LSB), out_valid 18 cycles after accept, sat=0.
- in_x=90852 (2·ln2) → k=2, out_y≈32'h0004_0000, latency 20 cycles.
- in_x=−45426 (−ln2) → k=−1, out_y≈32'h0000_8000; in_x=−1 → out_y≈32'h0000_FFFF.
- in_x=32'h0014_0000 (20.0) → k reaches 15, out_y=32'h7FFF_FFFF, sat=1, core_angle never leaves 0. in_x=−20.0 → out_y=0, sat=1.
- Hold out_ready=0 for 10 cycles in DONE → out_y stable, in_ready=0 throughout, in_valid pulses ignored; release → in_ready=1 on the following cycle.
- Assert rst for 1 cycle mid-WAIT → next edge out_valid=0, in_ready=1, core_xin=0; a following in_x=0 still produces 32'h0001_0000.

Source files
------------

// File: rtl/exp_range_sequencer.sv
// Range-reducing wrapper around the hyperbolic-CORDIC exp core: exp(x) = 2^k * exp(r), r in [0, ln2).
// Optional sat output port and flag register enabled by defining EXP_SAT_FLAG_EN.
module exp_range_sequencer #(
  parameter int                 XY_SZ     = 16,
  parameter int                 CORE_LAT  = 16,
  parameter int                 CORE_FRAC = 14,
  parameter logic [XY_SZ-1:0]   X_INIT    = 16'd19898,
  parameter logic signed [31:0] LN2_Q16   = 32'sd45426,
  parameter int                 MAX_K     = 14,
  parameter int                 MIN_K     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      in_x,
  output logic signed [31:0]      core_angle,
  output logic [XY_SZ-1:0]        core_xin,
  output logic [XY_SZ-1:0]        core_yin,
  input  logic signed [XY_SZ+1:0] core_exp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_y
`ifdef EXP_SAT_FLAG_EN
  ,
  output logic                    sat
`endif
);

  localparam int K_W   = 8;
  localparam int CNT_W = $clog2(CORE_LAT) + 1;
  localparam int unsigned SHL = (CORE_FRAC <= 16) ? (16 - CORE_FRAC) : 0;
  localparam int unsigned SHR = (CORE_FRAC > 16) ? (CORE_FRAC - 16) : 0;
  localparam logic signed [K_W-1:0] K_SAT   = K_W'(MAX_K + 1);
  localparam logic signed [K_W-1:0] K_FLUSH = K_W'(-(MIN_K + 1));

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_WAIT, S_SCALE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [31:0]      r_q, r_d;
  logic signed [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [31:0]      angle_q, angle_d;
  logic [XY_SZ-1:0]        xin_q, xin_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic [31:0]             y_q, y_d;
`ifdef EXP_SAT_FLAG_EN
  logic                    sat_q, sat_d;
`endif

  logic [XY_SZ+1:0]        exp_pos_s;
  logic [63:0]             v_s;
  logic [K_W-1:0]          shamt_s;
  logic [63:0]             scaled_s;

  // Scaling datapath: clamp negative core output, align to Q16.16, apply 2^k.
  always_comb begin
    exp_pos_s = core_exp[XY_SZ+1] ? {(XY_SZ+2){1'b0}} : core_exp;
    v_s       = (64'(exp_pos_s) << SHL) >> SHR;
    shamt_s   = k_q[K_W-1] ? -k_q : k_q;
    scaled_s  = k_q[K_W-1] ? (v_s >> shamt_s) : (v_s << shamt_s);
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    angle_d = angle_q;
    xin_d   = xin_q;
    ready_d = ready_q;
    valid_d = valid_q;
    y_d     = y_q;
`ifdef EXP_SAT_FLAG_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r_d     = in_x;
          k_d     = 8'sd0;
          ready_d = 1'b0;
          xin_d   = X_INIT;
          state_d = S_REDUCE;
`ifdef EXP_SAT_FLAG_EN
          sat_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDUCE: begin
        if (r_q < 32'sd0) begin
          r_d = r_q + LN2_Q16;
          k_d = k_q - 8'sd1;
        end else if (r_q >= LN2_Q16) begin
          r_d = r_q - LN2_Q16;
          k_d = k_q + 8'sd1;
        end else begin
          angle_d = r_q;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_WAIT;
        end
        // Exponent out of range: skip the core entirely.
        if (k_d == K_SAT) begin
          y_d     = 32'h7FFF_FFFF;
          valid_d = 1'b1;
          state_d = S_DONE;
`ifdef EXP_SAT_FLAG_EN
          sat_d   = 1'b1;
`endif
        end else if (k_d == K_FLUSH) begin
          y_d     = 32'h0000_0000;
          valid_d = 1'b1;
          state_d = S_DONE;
`ifdef EXP_SAT_FLAG_EN
          sat_d   = 1'b1;
`endif
        end else begin
          y_d = y_q;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(CORE_LAT - 1)) begin
          state_d = S_SCALE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_SCALE: begin
        if (scaled_s > 64'h0000_0000_7FFF_FFFF) begin
          y_d   = 32'h7FFF_FFFF;
`ifdef EXP_SAT_FLAG_EN
          sat_d = 1'b1;
`endif
        end else begin
          y_d = scaled_s[31:0];
        end
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          angle_d = 32'sd0;
          xin_d   = {XY_SZ{1'b0}};
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
        angle_d = 32'sd0;
        xin_d   = {XY_SZ{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= 32'sd0;
      k_q     <= 8'sd0;
      cnt_q   <= {CNT_W{1'b0}};
      angle_q <= 32'sd0;
      xin_q   <= {XY_SZ{1'b0}};
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      y_q     <= 32'h0000_0000;
`ifdef EXP_SAT_FLAG_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      angle_q <= angle_d;
      xin_q   <= xin_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      y_q     <= y_d;
`ifdef EXP_SAT_FLAG_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_y      = y_q;
  assign core_angle = angle_q;
  assign core_xin   = xin_q;
  assign core_yin   = {XY_SZ{1'b0}};
`ifdef EXP_SAT_FLAG_EN
  assign sat        = sat_q;
`endif

endmodule

// File: tb/tb_exp_range_sequencer.sv
// Directed bench for exp_range_sequencer with a pipelined behavioural exp core model.
// Checks the sat port only when EXP_SAT_FLAG_EN is defined.
module tb_exp_range_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_x = 32'sd0;
  logic signed [31:0] core_angle;
  logic [15:0]        core_xin;
  logic [15:0]        core_yin;
  logic signed [17:0] core_exp;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        out_y;
`ifdef EXP_SAT_FLAG_EN
  logic               sat;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exp_range_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .core_angle(core_angle), .core_xin(core_xin), .core_yin(core_yin), .core_exp(core_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
`ifdef EXP_SAT_FLAG_EN
    , .sat(sat)
`endif
  );

  always #5 clk = ~clk;

  // Core model: round(e^angle * 2^14), only meaningful when Xin carries the gain constant.
  function automatic logic [17:0] core_fn(input logic [31:0] ang, input logic [15:0] xin);
    real a;
    int  v;
    a = $itor($signed(ang)) / 65536.0;
    v = $rtoi($exp(a) * 16384.0 + 0.5);
    if (xin != 16'd19898) v = 0;
    return v[17:0];
  endfunction

  logic [17:0] pipe [16];
  always @(posedge clk) begin
    pipe[0] <= core_fn(core_angle, core_xin);
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end
  assign core_exp = pipe[15];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operand and wait (bounded) for out_valid; returns latency in cycles.
  task automatic run_txn(input logic [31:0] x, output int lat, output bit angle_moved);
    @(negedge clk);
    check_val("ready_before_accept", in_ready, 1'b1);
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    angle_moved = (core_angle != 32'sd0);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      if (core_angle != 32'sd0) angle_moved = 1'b1;
      if (!out_valid) lat++;
    end
    if (!out_valid) check_val("timeout_out_valid", 1'b0, 1'b1);
  endtask

  // Consume the result with out_ready high and check return to idle.
  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val({tag, "_ready_after"}, in_ready, 1'b1);
    check_val({tag, "_valid_after"}, out_valid, 1'b0);
    check_val({tag, "_xin_idle"}, core_xin, 16'd0);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    bit          sat_exp;
  } vec_t;

  vec_t vecs [7];
  int   lat;
  bit   moved;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"zero",    32'h0000_0000, 32'h0001_0000, 18, 1'b0};
    vecs[1] = '{"two_ln2", 32'd90852,     32'h0004_0000, 20, 1'b0};
    vecs[2] = '{"neg_ln2", 32'hFFFF_4E8E, 32'h0000_8000, 19, 1'b0};
    vecs[3] = '{"minus1",  32'hFFFF_FFFF, 32'h0000_FFFE, 19, 1'b0};
    vecs[4] = '{"one",     32'h0001_0000, 32'h0002_B7E0, 19, 1'b0};
    vecs[5] = '{"sat20",   32'h0014_0000, 32'h7FFF_FFFF, 15, 1'b1};
    vecs[6] = '{"flush20", 32'hFFEC_0000, 32'h0000_0000, 17, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_y", out_y, 32'h0);
    check_val("rst_core_angle", core_angle, 32'h0);
    check_val("rst_core_xin", core_xin, 16'h0);
    check_val("rst_core_yin", core_yin, 16'h0);
`ifdef EXP_SAT_FLAG_EN
    check_val("rst_sat", sat, 1'b0);
`endif
    repeat (20) @(posedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].x, lat, moved);
      check_val({vecs[i].tag, "_y"}, out_y, vecs[i].y);
      check_val({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
      check_val({vecs[i].tag, "_busy_ready"}, in_ready, 1'b0);
      if (vecs[i].sat_exp) check_val({vecs[i].tag, "_angle_moved"}, moved, 1'b0);
      else check_val({vecs[i].tag, "_xin_busy"}, core_xin, 16'd19898);
`ifdef EXP_SAT_FLAG_EN
      check_val({vecs[i].tag, "_sat"}, sat, vecs[i].sat_exp);
`endif
      release_out(vecs[i].tag);
    end

    // Backpressure: hold DONE, pulse in_valid, outputs must not move.
    out_ready = 1'b0;
    run_txn(32'h0000_0000, lat, moved);
    check_val("bp_y", out_y, 32'h0001_0000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = 32'h0003_0000;
      @(posedge clk);
      #1;
      check_val("bp_hold_y", out_y, 32'h0001_0000);
      check_val("bp_hold_valid", out_valid, 1'b1);
      check_val("bp_hold_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out("bp");

    // Reset mid-WAIT aborts, then a fresh operand still works.
    @(negedge clk);
    in_x = 32'h0000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_valid", out_valid, 1'b0);
    check_val("mid_rst_ready", in_ready, 1'b1);
    check_val("mid_rst_xin", core_xin, 16'd0);
    check_val("mid_rst_angle", core_angle, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(32'h0000_0000, lat, moved);
    check_val("post_rst_y", out_y, 32'h0001_0000);
    check_val("post_rst_lat", lat, 18);
    release_out("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
